audio_beep_decoder: RTL and testbench
=====================================

Name: audio_beep_decoder

Overview:
- Receive-side counterpart of the beep generator. Takes 12-bit microphone samples, detects a tone burst by windowed peak amplitude, and measures the burst duration.
- Converts the duration back into a 4-bit count, where one unit equals 10_000_000 clk100M cycles (0.1 s).
- Emits a one-cycle valid pulse with the decoded number.
- Sits between the mic sampler and game/menu logic, so a beep of N units played by another board decodes back to N.

Parameters:
- WINDOW_CYCLES, 1_000_000, clk100M cycles per amplitude window (10 ms). Must be > 20.
- WINDOWS_PER_UNIT, 10, windows per decoded unit (10 x 10 ms = 0.1 s).
- THRESHOLD, 300, minimum peak |sample - MIDSCALE| for a window to count as loud.
- GAP_WINDOWS, 2, consecutive quiet windows that end a tone.
- MIDSCALE, 2048, zero-signal sample value.

Ports:
- clk100M  input  1  system clock, 100 MHz.
- rst_n  input  1  asynchronous active-low reset.
- sample_valid  input  1  one-cycle strobe; mic_sample is valid this cycle.
- mic_sample  input  12  unsigned offset-binary sample.
- number_valid  output  1  one-cycle pulse; number and overflow are valid.
- number  output  4  decoded duration in units, 1..15.
- overflow  output  1  tone reached or exceeded 16 units after rounding; number is saturated to 15.
- tone_active  output  1  high in TONE state.
- level  output  12  peak amplitude of the last completed window.

Behaviour:
- Clock and reset:
  - Single clock domain: clk100M.
  - Reset is asynchronous and active-low (rst_n).
  - Reset values: all outputs 0; state IDLE; window counter 0; peak 0.
- Amplitude:
  - amp = |mic_sample - MIDSCALE|, computed in 13-bit signed, result 12-bit unsigned.
  - Sample 0 gives amp 2048; sample 4095 gives amp 2047.
- Window counter:
  - Free-running 0..WINDOW_CYCLES-1 from reset.
  - window_end is asserted on the cycle the count is WINDOW_CYCLES-1.
- Peak register:
  - On sample_valid, peak <= max(peak, amp).
  - On window_end: level <= max(peak, amp if sample_valid else 0), then peak clears to 0.
  - A sample arriving in the window_end cycle belongs to the closing window.
  - loud = (that closing value >= THRESHOLD).
- FSM states: IDLE, TONE, DIVIDE, REPORT.
  - IDLE: on window_end && loud -> TONE, win_cnt = 1, quiet_cnt = 0.
  - TONE, window_end && loud: win_cnt += quiet_cnt + 1 (bridged quiet windows count), quiet_cnt = 0.
  - TONE, window_end && !loud: quiet_cnt++. If quiet_cnt becomes GAP_WINDOWS -> DIVIDE.
  - TONE, win_cnt handling: win_cnt saturates at 16*WINDOWS_PER_UNIT. It is 8 bits wide for the defaults and is sized from the parameters.
  - DIVIDE entry: rem = win_cnt + WINDOWS_PER_UNIT/2 (round half up), q = 0, ovf = (rem >= 16*WINDOWS_PER_UNIT).
  - DIVIDE, each cycle: if rem >= WINDOWS_PER_UNIT and q < 15, then rem -= WINDOWS_PER_UNIT and q++. Otherwise -> REPORT.
  - DIVIDE takes at most 16 cycles.
  - REPORT, one cycle: if q != 0, number_valid = 1, number = q, overflow = ovf. Otherwise no pulse (glitch rejected). Then -> IDLE.
  - number and overflow hold their values until the next report.
- Windows during DIVIDE/REPORT:
  - window_end is ignored in DIVIDE and REPORT.
  - Peak/level logic continues regardless of FSM state.
- tone_active = (state == TONE).
- Decode latency:
  - number_valid arrives q+2 cycles after the window_end that completes the gap (DIVIDE entry + q subtractions + exit test + REPORT).
  - Exactly 2 + min(q,15) cycles for non-overflow cases.
- Boundary conditions:
  - Tone still sounding at reset release: detection starts fresh at the next window.
  - Reset mid-tone: tone discarded, no pulse.
  - A loud window in DIVIDE/REPORT is lost. The next loud window in IDLE starts a new tone.
  - Back-to-back tones separated by fewer than GAP_WINDOWS quiet windows merge into one.

Test Plan:
Bench overrides: WINDOW_CYCLES=100, WINDOWS_PER_UNIT=10, THRESHOLD=300, GAP_WINDOWS=2. sample_valid every 4 cycles. Tone = square wave 3048/1048 (amp 1000), silence = 2048.
1. Tone for 3000 cycles, then silence -> exactly one number_valid; number=3, overflow=0. tone_active high during the tone plus 2 windows.
2. Tone for 1200 cycles -> number=1. Tone for 1700 cycles -> number=2. Checks round-half-up across window misalignment.
3. Tone for 300 cycles (3-4 windows) -> q=0, no number_valid. Tone with amp 200 for 5000 cycles -> no pulse, tone_active stays 0, level=200.
4. Tone for 20000 cycles -> number=15, overflow=1. Pulse 17 cycles after gap completion.
5. Tone 1000 cycles, silence 100 cycles, tone 1000 cycles -> single pulse, number=2. Silence 300 cycles between the bursts instead -> two pulses, number=1 each.
6. rst_n low for 3 cycles mid-tone (asynchronously, off clock edge) -> all outputs 0 immediately, no pulse for that tone. Tone restarted afterwards for 3000 cycles -> number=3.

Source files
------------

// File: rtl/audio_beep_decoder_if.sv
// rtl/audio_beep_decoder_if.sv - mic sample input and decoded number output bundle
interface audio_beep_decoder_if;
  logic        sample_valid;
  logic [11:0] mic_sample;
  logic        number_valid;
  logic [3:0]  number;
  logic        overflow;
  logic        tone_active;
  logic [11:0] level;

  // master: mic sampler side that supplies samples and consumes the decoded number
  modport master (
    output sample_valid, mic_sample,
    input  number_valid, number, overflow, tone_active, level
  );

  // slave: the decoder itself
  modport slave (
    input  sample_valid, mic_sample,
    output number_valid, number, overflow, tone_active, level
  );
endinterface

// File: rtl/audio_beep_decoder.sv
// rtl/audio_beep_decoder.sv - tone burst detector and duration-to-number decoder
module audio_beep_decoder #(
  parameter int WINDOW_CYCLES    = 1_000_000,
  parameter int WINDOWS_PER_UNIT = 10,
  parameter int THRESHOLD        = 300,
  parameter int GAP_WINDOWS      = 2,
  parameter int MIDSCALE         = 2048
) (
  input  logic                 clk100M,
  input  logic                 rst_n,
  audio_beep_decoder_if.slave  bus
);
  localparam int WIN_MAX = 16 * WINDOWS_PER_UNIT;
  localparam int REM_MAX = WIN_MAX + WINDOWS_PER_UNIT / 2;
  localparam int CW      = $clog2(WINDOW_CYCLES);
  localparam int NW      = $clog2(REM_MAX + 1);
  localparam int QW      = (GAP_WINDOWS > 1) ? $clog2(GAP_WINDOWS + 1) : 1;

  typedef enum logic [1:0] {IDLE, TONE, DIVIDE, REPORT} state_t;

  state_t          state;
  logic [CW-1:0]   win_pos;
  logic            window_end;
  logic signed [12:0] diff;
  logic [11:0]     amp;
  logic [11:0]     cand;
  logic [11:0]     closing;
  logic            loud;
  logic [11:0]     peak;
  logic [11:0]     level_q;
  logic [NW-1:0]   win_cnt;
  logic [NW:0]     win_sum;
  logic [NW-1:0]   rem_init;
  logic [NW-1:0]   rem;
  logic [QW-1:0]   quiet_cnt;
  logic [3:0]      q;
  logic            ovf;
  logic            number_valid_q;
  logic [3:0]      number_q;
  logic            overflow_q;

  assign window_end = (win_pos == CW'(WINDOW_CYCLES - 1));

  // Amplitude is distance from midscale; sample 0 yields 2048, which still fits 12 bits.
  assign diff = 13'({1'b0, bus.mic_sample}) - 13'(MIDSCALE);
  assign amp  = diff[12] ? 12'(-diff) : 12'(diff);

  // A sample landing on window_end belongs to the window that is closing.
  assign cand    = bus.sample_valid ? amp : 12'd0;
  assign closing = (cand > peak) ? cand : peak;
  assign loud    = (closing >= 12'(THRESHOLD));

  // Bridged quiet windows are folded into the tone length when the tone resumes.
  assign win_sum  = (NW+1)'(win_cnt) + (NW+1)'(quiet_cnt) + (NW+1)'(1);
  assign rem_init = win_cnt + NW'(WINDOWS_PER_UNIT / 2);

  assign bus.number_valid = number_valid_q;
  assign bus.number       = number_q;
  assign bus.overflow     = overflow_q;
  assign bus.tone_active  = (state == TONE);
  assign bus.level        = level_q;

  // Free-running window position, independent of the decoder state.
  always_ff @(posedge clk100M or negedge rst_n) begin
    if (!rst_n)          win_pos <= '0;
    else if (window_end) win_pos <= '0;
    else                 win_pos <= win_pos + CW'(1);
  end

  // Track the running peak and publish it as level when each window closes.
  always_ff @(posedge clk100M or negedge rst_n) begin
    if (!rst_n) begin
      peak    <= '0;
      level_q <= '0;
    end else if (window_end) begin
      level_q <= closing;
      peak    <= '0;
    end else if (bus.sample_valid) begin
      peak    <= closing;
    end
  end

  // Tone segmentation, rounded division by the unit length, and the one-cycle report.
  always_ff @(posedge clk100M or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      win_cnt        <= '0;
      quiet_cnt      <= '0;
      rem            <= '0;
      q              <= '0;
      ovf            <= 1'b0;
      number_valid_q <= 1'b0;
      number_q       <= '0;
      overflow_q     <= 1'b0;
    end else begin
      number_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (window_end && loud) begin
            state     <= TONE;
            win_cnt   <= NW'(1);
            quiet_cnt <= '0;
          end
        end
        TONE: begin
          if (window_end) begin
            if (loud) begin
              win_cnt   <= (win_sum >= (NW+1)'(WIN_MAX)) ? NW'(WIN_MAX) : win_sum[NW-1:0];
              quiet_cnt <= '0;
            end else if (quiet_cnt == QW'(GAP_WINDOWS - 1)) begin
              quiet_cnt <= '0;
              state     <= DIVIDE;
              rem       <= rem_init;
              q         <= '0;
              ovf       <= (rem_init >= NW'(WIN_MAX));
            end else begin
              quiet_cnt <= quiet_cnt + QW'(1);
            end
          end
        end
        DIVIDE: begin
          if ((rem >= NW'(WINDOWS_PER_UNIT)) && (q != 4'd15)) begin
            rem <= rem - NW'(WINDOWS_PER_UNIT);
            q   <= q + 4'd1;
          end else begin
            state <= REPORT;
            if (q != 4'd0) begin
              number_valid_q <= 1'b1;
              number_q       <= q;
              overflow_q     <= ovf;
            end
          end
        end
        REPORT: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_audio_beep_decoder.sv
// tb/tb_audio_beep_decoder.sv - self-checking bench for audio_beep_decoder
module tb_audio_beep_decoder;
  localparam int WC   = 100;
  localparam int WPU  = 10;
  localparam int TH   = 300;
  localparam int GAP  = 2;
  localparam int MID  = 2048;
  localparam int MAXC = 21000;
  localparam int PAD  = 600;

  typedef struct {
    int lead; int t1; int a1; int gap; int t2; int a2;
    int exp_n; int exp_num; int exp_ovf; int exp_peak;
  } vec_t;

  typedef struct { int t; int num; int ovf; } pulse_t;

  logic clk100M = 1'b0;
  logic rst_n   = 1'b0;

  audio_beep_decoder_if bus();

  audio_beep_decoder #(
    .WINDOW_CYCLES(WC), .WINDOWS_PER_UNIT(WPU), .THRESHOLD(TH),
    .GAP_WINDOWS(GAP), .MIDSCALE(MID)
  ) dut (
    .clk100M(clk100M),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk100M = ~clk100M;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;
  int ncyc;
  logic rec_en = 1'b0;
  logic sv_tog = 1'b0;
  logic act_ta [MAXC];
  logic exp_ta [MAXC];
  logic [11:0] act_lvl [MAXC];
  int win_peak [MAXC/WC + 2];
  pulse_t act_q[$];
  pulse_t exp_q[$];

  // Cycle index since reset release; cycle c is the interval before the c-th active edge.
  always @(posedge clk100M or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Output monitor, sampled on the falling edge.
  always @(negedge clk100M) begin
    if (rec_en && rst_n && cyc < MAXC) begin
      act_ta[cyc]  = bus.tone_active;
      act_lvl[cyc] = bus.level;
      if (bus.number_valid) act_q.push_back('{cyc, int'(bus.number), int'(bus.overflow)});
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk100M);
    #3;
    rst_n = 1'b0;
    bus.sample_valid = 1'b0;
    bus.mic_sample   = 12'd2048;
    repeat (3) @(posedge clk100M);
    #2;
    rst_n = 1'b1;
  endtask

  // Square wave of amplitude a around midscale; a = 0 is silence. Off-strobe data is junk.
  task automatic play(input int n, input int a, input int phase);
    int hi, lo, smp, amp;
    hi = (MID + a > 4095) ? 4095 : MID + a;
    lo = (MID - a < 0) ? 0 : MID - a;
    for (int i = 0; i < n; i++) begin
      @(negedge clk100M);
      if (cyc % 4 == phase) begin
        sv_tog = ~sv_tog;
        smp = sv_tog ? hi : lo;
        bus.sample_valid = 1'b1;
        bus.mic_sample   = 12'(smp);
        amp = (smp >= MID) ? smp - MID : MID - smp;
        if (amp > win_peak[cyc / WC]) win_peak[cyc / WC] = amp;
      end else begin
        bus.sample_valid = 1'b0;
        bus.mic_sample   = 12'($urandom);
      end
      ncyc++;
    end
  endtask

  // Reference: group loud windows whose separation leaves fewer than GAP quiet windows,
  // then turn each group length into a rounded unit count.
  task automatic build_model();
    int loud_q[$];
    int nwin, i, first, last, close_c, wins, rem, q, ovf, hi_c;
    exp_q.delete();
    for (int c = 0; c < ncyc; c++) exp_ta[c] = 1'b0;
    nwin = ncyc / WC;
    for (int w = 0; w < nwin; w++) if (win_peak[w] >= TH) loud_q.push_back(w);
    i = 0;
    while (i < loud_q.size()) begin
      first = loud_q[i];
      last  = first;
      while (i + 1 < loud_q.size() && loud_q[i+1] - last <= GAP) begin
        i++;
        last = loud_q[i];
      end
      i++;
      close_c = WC * (last + GAP) + WC - 1;
      hi_c = (close_c < ncyc - 1) ? close_c : ncyc - 1;
      for (int c = WC * first + WC; c <= hi_c; c++) exp_ta[c] = 1'b1;
      wins = last - first + 1;
      if (wins > 16 * WPU) wins = 16 * WPU;
      rem = wins + WPU / 2;
      q   = (rem / WPU > 15) ? 15 : rem / WPU;
      ovf = (rem >= 16 * WPU) ? 1 : 0;
      if (q > 0 && close_c + q + 2 < ncyc) exp_q.push_back('{close_c + q + 2, q, ovf});
    end
  endtask

  task automatic run_scn(input vec_t v, input int phase, input bit rst, input bit use_exp,
                         input string tag);
    int ta_bad, lvl_bad, maxlvl, exp_l, npair;
    rec_en = 1'b0;
    if (rst) do_reset();
    for (int w = 0; w < MAXC/WC + 2; w++) win_peak[w] = 0;
    act_q.delete();
    ncyc = 0;
    rec_en = 1'b1;
    play(v.lead, 0, phase);
    play(v.t1, v.a1, phase);
    play(v.gap, 0, phase);
    play(v.t2, v.a2, phase);
    play(PAD, 0, phase);
    @(posedge clk100M);
    rec_en = 1'b0;

    build_model();
    ta_bad = 0; lvl_bad = 0; maxlvl = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (act_ta[c] !== exp_ta[c]) ta_bad++;
      exp_l = (c >= WC) ? win_peak[c / WC - 1] : 0;
      if (int'(act_lvl[c]) != exp_l) lvl_bad++;
      if (int'(act_lvl[c]) > maxlvl) maxlvl = int'(act_lvl[c]);
    end
    check({tag, " tone_active trace mismatches"}, ta_bad, 0);
    check({tag, " level trace mismatches"}, lvl_bad, 0);
    check({tag, " pulse count vs model"}, act_q.size(), exp_q.size());
    npair = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int k = 0; k < npair; k++) begin
      check($sformatf("%s pulse%0d cycle", tag, k), act_q[k].t, exp_q[k].t);
      check($sformatf("%s pulse%0d number", tag, k), act_q[k].num, exp_q[k].num);
      check($sformatf("%s pulse%0d overflow", tag, k), act_q[k].ovf, exp_q[k].ovf);
    end
    if (use_exp) begin
      check({tag, " pulse count"}, act_q.size(), v.exp_n);
      foreach (act_q[k]) begin
        check($sformatf("%s number%0d", tag, k), act_q[k].num, v.exp_num);
        check($sformatf("%s overflow%0d", tag, k), act_q[k].ovf, v.exp_ovf);
      end
      check({tag, " peak level"}, maxlvl, v.exp_peak);
    end
  endtask

  initial begin
    vec_t tbl[11];
    vec_t v6;
    vec_t rv;

    bus.sample_valid = 1'b0;
    bus.mic_sample   = 12'd2048;
    rst_n = 1'b0;
    #12;
    check("reset number_valid", int'(bus.number_valid), 0);
    check("reset number", int'(bus.number), 0);
    check("reset overflow", int'(bus.overflow), 0);
    check("reset tone_active", int'(bus.tone_active), 0);
    check("reset level", int'(bus.level), 0);

    //          lead  t1    a1    gap  t2    a2    n  num ovf peak
    tbl[0]  = '{150, 3000,  1000, 0,   0,    0,    1, 3,  0,  1000};
    tbl[1]  = '{150, 1200,  1000, 0,   0,    0,    1, 1,  0,  1000};
    tbl[2]  = '{150, 1700,  1000, 0,   0,    0,    1, 2,  0,  1000};
    tbl[3]  = '{150, 300,   1000, 0,   0,    0,    0, 0,  0,  1000};
    tbl[4]  = '{150, 5000,  200,  0,   0,    0,    0, 0,  0,  200};
    tbl[5]  = '{150, 20000, 1000, 0,   0,    0,    1, 15, 1,  1000};
    tbl[6]  = '{150, 1000,  1000, 100, 1000, 1000, 1, 2,  0,  1000};
    tbl[7]  = '{150, 1000,  1000, 300, 1000, 1000, 2, 1,  0,  1000};
    tbl[8]  = '{150, 1200,  2048, 0,   0,    0,    1, 1,  0,  2048};
    tbl[9]  = '{150, 1200,  300,  0,   0,    0,    1, 1,  0,  300};
    tbl[10] = '{150, 1200,  299,  0,   0,    0,    0, 0,  0,  299};
    for (int k = 0; k < 11; k++) run_scn(tbl[k], 0, 1'b1, 1'b1, $sformatf("vec%0d", k));

    // Asynchronous reset in the middle of a sounding tone.
    do_reset();
    for (int w = 0; w < MAXC/WC + 2; w++) win_peak[w] = 0;
    act_q.delete();
    ncyc = 0;
    rec_en = 1'b1;
    play(1500, 1000, 0);
    check("midreset tone_active before", int'(bus.tone_active), 1);
    check("midreset level before", int'(bus.level), 1000);
    #3;
    rst_n = 1'b0;
    #1;
    check("midreset number_valid", int'(bus.number_valid), 0);
    check("midreset number", int'(bus.number), 0);
    check("midreset overflow", int'(bus.overflow), 0);
    check("midreset tone_active", int'(bus.tone_active), 0);
    check("midreset level", int'(bus.level), 0);
    bus.sample_valid = 1'b0;
    bus.mic_sample   = 12'd3048;
    repeat (3) @(posedge clk100M);
    #2;
    rst_n = 1'b1;
    rec_en = 1'b0;
    check("midreset pulses before reset", act_q.size(), 0);
    v6 = '{0, 200, 1000, 400, 3000, 1000, 1, 3, 0, 1000};
    run_scn(v6, 0, 1'b0, 1'b1, "midreset");

    for (int r = 0; r < 5; r++) begin
      rv.lead = $urandom_range(0, 199);
      rv.t1   = $urandom_range(100, 2500);
      rv.a1   = $urandom_range(0, 2048);
      rv.gap  = $urandom_range(0, 400);
      rv.t2   = $urandom_range(0, 1500);
      rv.a2   = $urandom_range(0, 2048);
      rv.exp_n = 0; rv.exp_num = 0; rv.exp_ovf = 0; rv.exp_peak = 0;
      run_scn(rv, $urandom_range(0, 3), 1'b1, 1'b0, $sformatf("rand%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
